imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The parameter list SHALL be exactly as follows, one per line (name, default, meaning):
- DATA_W, 16, result width; legal values are >= 16.
- IN_W, 11, immediate field width; legal values are 11..DATA_W-1.
REQ-002 The ports SHALL be exactly as follows, one per line (name  direction  width  meaning):
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an input request is present.
- in_ready  out  1  the block can accept a request.
- in_imm  in  IN_W  raw immediate field from the instruction.
- in_mode  in  3  extension mode.
- in_rs  in  DATA_W  source operand, used by mode 5 only.
- flush  in  1  synchronous discard of all held requests.
- out_valid  out  1  a result is present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  the extended result.
- out_err  out  1  the result came from an illegal mode.

Function
REQ-003 Mode encoding SHALL be:
- 0 = zero-extend in_imm[4:0].
- 1 = sign-extend in_imm[4:0].
- 2 = sign-extend in_imm[7:0].
- 3 = zero-extend in_imm[7:0].
- 4 = sign-extend in_imm[IN_W-1:0].
- 5 = shift-merge: {in_rs[DATA_W-9:0], in_imm[7:0]}.
- 6 and 7 = illegal.
REQ-004 In sign-extend modes, the sign bit of the selected field SHALL be replicated through out_data[DATA_W-1].
REQ-005 Illegal modes SHALL produce out_data = 0 and out_err = 1; all legal modes SHALL produce out_err = 0.
REQ-006 The extension result SHALL be computed combinationally at acceptance and stored registered; out_data and out_err SHALL be registered outputs.
REQ-007 A request SHALL be accepted on a rising edge where in_valid = 1 and in_ready = 1.
REQ-008 Storage SHALL be two entries: an output register (OUT) and a skid register (SKID). Validity state SHALL be EMPTY, ONE (OUT valid) or TWO (OUT and SKID valid).
REQ-009 in_ready SHALL be registered and SHALL equal 1 exactly when SKID is not valid.
REQ-010 out_valid SHALL equal the OUT valid bit.
REQ-011 Latency SHALL be one cycle: a request accepted at edge N SHALL appear on out_data after edge N when OUT is empty or draining at edge N.
REQ-012 Transitions:
- EMPTY + accept -> ONE.
- ONE + accept + out_ready -> ONE, OUT loaded with the new result.
- ONE + accept + !out_ready -> TWO, new result loaded into SKID.
- ONE + !accept + out_ready -> EMPTY.
- TWO + out_ready -> ONE, SKID moves into OUT.
- TWO + !out_ready -> TWO, holding.
REQ-013 Results SHALL leave in acceptance order, with no loss or duplication.
REQ-014 While out_valid = 1 and out_ready = 0, out_data and out_err SHALL remain stable.
REQ-015 flush = 1 at an edge SHALL force EMPTY and in_ready = 1 after that edge, and SHALL discard any request presented at the same edge. flush SHALL take priority over accept and over out_ready.
REQ-016 No combinational path SHALL exist from out_ready to in_ready.

Reset
REQ-017 While rst_n = 0, regardless of clk, the block SHALL hold: out_valid = 0, in_ready = 0, out_data = 0, out_err = 0, SKID cleared.
REQ-018 On the first rising edge after rst_n deasserts, in_ready SHALL become 1.
REQ-019 Reset asserted mid-transfer SHALL discard held entries; no result SHALL appear after reset releases until a new request is accepted.

Verification
REQ-020 The bench SHALL cover these directed scenarios, with DATA_W = 16 and IN_W = 11:
- Modes 0/1/2/4 with imm = 0x01F / 0x01F / 0x080 / 0x400, out_ready = 1 -> out_data = 0x001F / 0xFFFF / 0xFF80 / 0xFC00, each one cycle after acceptance, out_err = 0.
- Mode 5 with in_rs = 0x12AB and imm = 0x0CD -> out_data = 0xABCD.
- Mode 6 -> out_data = 0x0000 and out_err = 1.
- Backpressure: out_ready = 0 with three back-to-back requests A, B, C -> A and B accepted, in_ready = 0 from the cycle after B, C held at the input. Then out_ready = 1 -> results emerge in order A, B, C, with out_data stable while stalled.
- Flush in state TWO together with a new in_valid -> after the edge out_valid = 0 and in_ready = 1; neither the held results nor the new request ever appear.
- rst_n pulsed low asynchronously in state ONE, between clock edges -> out_valid drops to 0 immediately; no output appears after release until a new request is accepted.
- Each scenario SHALL be repeated at DATA_W = 32 and IN_W = 11: mode 4 with imm = 0x400 -> 0xFFFFFC00.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate-extension stage with a two-entry output buffer.
// Each accepted request is extended combinationally, then held in an output
// register (OUT) with a skid register (SKID) behind it. The skid register lets
// in_ready come straight from a flop, so out_ready never feeds in_ready
// combinationally.
module imm_extend_pipe #(
  parameter int DATA_W = 16,
  parameter int IN_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_rs,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  typedef enum logic [2:0] {
    MODE_ZEXT5 = 3'd0,
    MODE_SEXT5 = 3'd1,
    MODE_SEXT8 = 3'd2,
    MODE_ZEXT8 = 3'd3,
    MODE_SEXTF = 3'd4,
    MODE_MERGE = 3'd5
  } mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } entry_t;

  entry_t ext;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  logic   accept;

  // Extension of the incoming request; modes 6 and 7 yield zero with err set.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    ext.data = '0;
    ext.err  = 1'b0;
    case (mode_e'(in_mode))
      MODE_ZEXT5: ext.data = {{(DATA_W-5){1'b0}}, in_imm[4:0]};
      MODE_SEXT5: ext.data = {{(DATA_W-5){in_imm[4]}}, in_imm[4:0]};
      MODE_SEXT8: ext.data = {{(DATA_W-8){in_imm[7]}}, in_imm[7:0]};
      MODE_ZEXT8: ext.data = {{(DATA_W-8){1'b0}}, in_imm[7:0]};
      MODE_SEXTF: ext.data = {{(DATA_W-IN_W){in_imm[IN_W-1]}}, in_imm};
      MODE_MERGE: ext.data = {in_rs[DATA_W-9:0], in_imm[7:0]};
      default:    ext.err  = 1'b1;
    endcase
  end

  // in_ready is a flop and is low whenever SKID is full, so TWO never accepts.
  assign accept = in_valid && in_ready_q;

  // Next-state for the OUT/SKID pair; flush overrides accept and out_ready.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // TWO: drain SKID into OUT when downstream takes OUT, else hold.
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (out_valid_q) begin
      // ONE: replace OUT, spill into SKID, or empty out.
      if (accept && out_ready) begin
        out_d = ext;
      end else if (accept) begin
        skid_d       = ext;
        skid_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // EMPTY: new result goes straight to OUT for one-cycle latency.
      out_d       = ext;
      out_valid_d = 1'b1;
    end
  end

  // State registers; in_ready stays low through reset and rises on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are reset too, because out_data must read zero
    // and SKID must be cleared while reset is held, not just marked invalid.
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the values
      // computed from the pre-edge state regardless of statement order.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_err   = out_q.err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe. Two instances (16-bit and 32-bit results)
// run in lockstep on shared control inputs; each scenario checks both.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [10:0] in_imm;
  logic [2:0]  in_mode;
  logic [15:0] in_rs16;
  logic [31:0] in_rs32;
  logic        flush;
  logic        out_ready;

  logic        in_ready16, out_valid16, out_err16;
  logic [15:0] out_data16;
  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_data32;

  int total = 0;
  int bad   = 0;

  imm_extend_pipe #(.DATA_W(16), .IN_W(11)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_imm(in_imm), .in_mode(in_mode), .in_rs(in_rs16), .flush(flush),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_err(out_err16)
  );

  imm_extend_pipe #(.DATA_W(32), .IN_W(11)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_imm(in_imm), .in_mode(in_mode), .in_rs(in_rs32), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .out_err(out_err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [10:0] imm);
    in_valid = v;
    in_mode  = m;
    in_imm   = imm;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset out_valid16 got=%b exp=0", out_valid16); end
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL reset out_valid32 got=%b exp=0", out_valid32); end
    total++; if (in_ready16 !== 1'b0) begin bad++; $display("FAIL reset in_ready16 got=%b exp=0", in_ready16); end
    total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL reset in_ready32 got=%b exp=0", in_ready32); end
    total++; if (out_data16 !== 16'h0000) begin bad++; $display("FAIL reset out_data16 got=%h exp=0000", out_data16); end
    total++; if (out_data32 !== 32'h0) begin bad++; $display("FAIL reset out_data32 got=%h exp=00000000", out_data32); end
    total++; if (out_err16 !== 1'b0 || out_err32 !== 1'b0) begin bad++; $display("FAIL reset out_err got=%b/%b exp=0/0", out_err16, out_err32); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready16 !== 1'b1) begin bad++; $display("FAIL release in_ready16 got=%b exp=1", in_ready16); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL release in_ready32 got=%b exp=1", in_ready32); end
    total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL release out_valid got=%b/%b exp=0/0", out_valid16, out_valid32); end
  endtask

  task automatic test_modes();
    logic [2:0]  modes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd3, 3'd7};
    logic [10:0] imms  [8] = '{11'h01F, 11'h01F, 11'h080, 11'h400, 11'h0CD, 11'h000, 11'h480, 11'h3FF};
    logic [15:0] exp16 [8] = '{16'h001F, 16'hFFFF, 16'hFF80, 16'hFC00, 16'hABCD, 16'h0000, 16'h0080, 16'h0000};
    logic [31:0] exp32 [8] = '{32'h0000001F, 32'hFFFFFFFF, 32'hFFFFFF80, 32'hFFFFFC00,
                               32'h0012ABCD, 32'h00000000, 32'h00000080, 32'h00000000};
    logic        experr[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    in_rs16   = 16'h12AB;
    in_rs32   = 32'h000012AB;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, modes[i], imms[i]);
      tick();
      drive(1'b0, 3'd0, 11'h000);
      total++; if (out_valid16 !== 1'b1 || out_valid32 !== 1'b1) begin bad++; $display("FAIL mode%0d out_valid got=%b/%b exp=1/1", modes[i], out_valid16, out_valid32); end
      total++; if (out_data16 !== exp16[i]) begin bad++; $display("FAIL mode%0d out_data16 got=%h exp=%h", modes[i], out_data16, exp16[i]); end
      total++; if (out_data32 !== exp32[i]) begin bad++; $display("FAIL mode%0d out_data32 got=%h exp=%h", modes[i], out_data32, exp32[i]); end
      total++; if (out_err16 !== experr[i] || out_err32 !== experr[i]) begin bad++; $display("FAIL mode%0d out_err got=%b/%b exp=%b", modes[i], out_err16, out_err32, experr[i]); end
      tick();
      total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL mode%0d drain out_valid got=%b/%b exp=0/0", modes[i], out_valid16, out_valid32); end
    end
  endtask

  task automatic test_backpressure();
    // A = mode3 0x0A1, B = mode1 0x011 (sign of bit4), C = mode4 0x2AA (positive)
    logic [15:0] e16 [3] = '{16'h00A1, 16'hFFF1, 16'h02AA};
    logic [31:0] e32 [3] = '{32'h000000A1, 32'hFFFFFFF1, 32'h000002AA};
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 11'h0A1);
    tick();
    total++; if (out_data16 !== e16[0] || out_data32 !== e32[0]) begin bad++; $display("FAIL bp A data got=%h/%h exp=%h/%h", out_data16, out_data32, e16[0], e32[0]); end
    total++; if (in_ready16 !== 1'b1 || in_ready32 !== 1'b1) begin bad++; $display("FAIL bp after A in_ready got=%b/%b exp=1/1", in_ready16, in_ready32); end
    drive(1'b1, 3'd1, 11'h011);
    tick();
    total++; if (in_ready16 !== 1'b0 || in_ready32 !== 1'b0) begin bad++; $display("FAIL bp after B in_ready got=%b/%b exp=0/0", in_ready16, in_ready32); end
    total++; if (out_data16 !== e16[0] || out_data32 !== e32[0]) begin bad++; $display("FAIL bp stall1 data got=%h/%h exp=%h/%h", out_data16, out_data32, e16[0], e32[0]); end
    drive(1'b1, 3'd4, 11'h2AA);
    tick();
    total++; if (in_ready16 !== 1'b0 || in_ready32 !== 1'b0) begin bad++; $display("FAIL bp C held in_ready got=%b/%b exp=0/0", in_ready16, in_ready32); end
    total++; if (out_valid16 !== 1'b1 || out_data16 !== e16[0] || out_data32 !== e32[0]) begin bad++; $display("FAIL bp stall2 data got=%h/%h exp=%h/%h", out_data16, out_data32, e16[0], e32[0]); end
    out_ready = 1'b1;
    tick();
    total++; if (out_data16 !== e16[1] || out_data32 !== e32[1]) begin bad++; $display("FAIL bp B data got=%h/%h exp=%h/%h", out_data16, out_data32, e16[1], e32[1]); end
    total++; if (in_ready16 !== 1'b1 || in_ready32 !== 1'b1) begin bad++; $display("FAIL bp after drain in_ready got=%b/%b exp=1/1", in_ready16, in_ready32); end
    tick();
    drive(1'b0, 3'd0, 11'h000);
    total++; if (out_valid16 !== 1'b1 || out_data16 !== e16[2] || out_data32 !== e32[2]) begin bad++; $display("FAIL bp C data got=%h/%h exp=%h/%h", out_data16, out_data32, e16[2], e32[2]); end
    tick();
    total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL bp no-dup out_valid got=%b/%b exp=0/0", out_valid16, out_valid32); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 11'h003);
    tick();
    drive(1'b1, 3'd0, 11'h004);
    tick();
    total++; if (in_ready16 !== 1'b0 || in_ready32 !== 1'b0) begin bad++; $display("FAIL flush setup TWO in_ready got=%b/%b exp=0/0", in_ready16, in_ready32); end
    drive(1'b1, 3'd0, 11'h005);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 11'h000);
    total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL flush TWO out_valid got=%b/%b exp=0/0", out_valid16, out_valid32); end
    total++; if (in_ready16 !== 1'b1 || in_ready32 !== 1'b1) begin bad++; $display("FAIL flush TWO in_ready got=%b/%b exp=1/1", in_ready16, in_ready32); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL flush TWO leak cycle%0d out_valid got=%b/%b exp=0/0", i, out_valid16, out_valid32); end
    end
    // Flush in ONE while in_ready=1: the same-edge request must be dropped.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 11'h006);
    tick();
    total++; if (out_valid16 !== 1'b1 || out_data16 !== 16'h0006) begin bad++; $display("FAIL flush ONE setup got=%b/%h exp=1/0006", out_valid16, out_data16); end
    drive(1'b1, 3'd0, 11'h007);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 11'h000);
    total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL flush ONE out_valid got=%b/%b exp=0/0", out_valid16, out_valid32); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL flush ONE leak cycle%0d out_valid got=%b/%b exp=0/0", i, out_valid16, out_valid32); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 11'h055);
    tick();
    drive(1'b0, 3'd0, 11'h000);
    total++; if (out_valid16 !== 1'b1 || out_valid32 !== 1'b1) begin bad++; $display("FAIL areset setup out_valid got=%b/%b exp=1/1", out_valid16, out_valid32); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL areset out_valid got=%b/%b exp=0/0", out_valid16, out_valid32); end
    total++; if (in_ready16 !== 1'b0 || in_ready32 !== 1'b0) begin bad++; $display("FAIL areset in_ready got=%b/%b exp=0/0", in_ready16, in_ready32); end
    total++; if (out_data16 !== 16'h0 || out_data32 !== 32'h0) begin bad++; $display("FAIL areset out_data got=%h/%h exp=0/0", out_data16, out_data32); end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin bad++; $display("FAIL areset leak cycle%0d out_valid got=%b/%b exp=0/0", i, out_valid16, out_valid32); end
    end
    total++; if (in_ready16 !== 1'b1 || in_ready32 !== 1'b1) begin bad++; $display("FAIL areset release in_ready got=%b/%b exp=1/1", in_ready16, in_ready32); end
    drive(1'b1, 3'd2, 11'h0FE);
    tick();
    drive(1'b0, 3'd0, 11'h000);
    total++; if (out_valid16 !== 1'b1 || out_data16 !== 16'hFFFE) begin bad++; $display("FAIL areset new req16 got=%b/%h exp=1/fffe", out_valid16, out_data16); end
    total++; if (out_valid32 !== 1'b1 || out_data32 !== 32'hFFFFFFFE) begin bad++; $display("FAIL areset new req32 got=%b/%h exp=1/fffffffe", out_valid32, out_data32); end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    in_rs16   = '0;
    in_rs32   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_modes();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
